// File: rtl/seq_scan_if.sv
// Handshake/config/status bundle for the scan controller.
//   master: test/config side (drives start, cfg_*, abort and the serial stream)
//   slave : seq_scan_ctrl (drives busy, match, match_count, done, limit_hit, aborted)
interface seq_scan_if #(
  parameter int unsigned PAT_W = 4,
  parameter int unsigned CNT_W = 8
);
  logic             start;
  logic [PAT_W-1:0] cfg_pattern;
  logic             cfg_overlap;
  logic [CNT_W-1:0] cfg_window;
  logic [CNT_W-1:0] cfg_max_match;
  logic             abort;
  logic             in_valid;
  logic             in;
  logic             busy;
  logic             match;
  logic [CNT_W-1:0] match_count;
  logic             done;
  logic             limit_hit;
  logic             aborted;

  modport master (
    output start, cfg_pattern, cfg_overlap, cfg_window, cfg_max_match, abort, in_valid, in,
    input  busy, match, match_count, done, limit_hit, aborted
  );

  modport slave (
    input  start, cfg_pattern, cfg_overlap, cfg_window, cfg_max_match, abort, in_valid, in,
    output busy, match, match_count, done, limit_hit, aborted
  );
endinterface

// File: rtl/seq_scan_ctrl.sv
// Bounded, restartable scan controller around a serial Moore pattern detector.
// A start in IDLE latches the config and runs one scan over the gated serial stream,
// counting pattern hits, then pulses done for one cycle with the count and the cause.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - seq_scan_if slave: start/cfg_*/abort/in_valid/in in; busy/match/match_count/
//          done/limit_hit/aborted out
module seq_scan_ctrl #(
  parameter int unsigned PAT_W = 4,
  parameter int unsigned CNT_W = 8
) (
  input logic    clk,
  input logic    rst,
  seq_scan_if.slave bus
);

  localparam int unsigned FillW = $clog2(PAT_W + 1);
  localparam logic [FillW-1:0] FillFull = FillW'(PAT_W);

  typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

  state_e           state_q, state_d;
  logic [PAT_W-1:0] pattern_q, pattern_d;
  logic             overlap_q, overlap_d;
  logic [CNT_W-1:0] window_q, window_d;
  logic [CNT_W-1:0] max_q, max_d;
  logic [PAT_W-1:0] hist_q, hist_d;
  logic [FillW-1:0] fill_q, fill_d;
  logic [CNT_W-1:0] bits_q, bits_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             match_q, match_d;
  logic             limit_q, limit_d;
  logic             aborted_q, aborted_d;

  logic [PAT_W-1:0] hist_nxt;
  logic [FillW-1:0] fill_nxt;
  logic             hit;
  logic             lim_reached;

  always_comb begin
    state_d     = state_q;
    pattern_d   = pattern_q;
    overlap_d   = overlap_q;
    window_d    = window_q;
    max_d       = max_q;
    hist_d      = hist_q;
    fill_d      = fill_q;
    bits_d      = bits_q;
    count_d     = count_q;
    match_d     = 1'b0;
    limit_d     = limit_q;
    aborted_d   = aborted_q;
    hist_nxt    = {hist_q[PAT_W-2:0], bus.in};
    fill_nxt    = (fill_q == FillFull) ? FillFull : fill_q + FillW'(1);
    hit         = 1'b0;
    lim_reached = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          pattern_d = bus.cfg_pattern;
          overlap_d = bus.cfg_overlap;
          window_d  = bus.cfg_window;
          max_d     = bus.cfg_max_match;
          count_d   = '0;
          limit_d   = 1'b0;
          aborted_d = 1'b0;
          hist_d    = '0;
          fill_d    = '0;
          bits_d    = '0;
          state_d   = (bus.cfg_window == '0) ? StDone : StScan;
        end
      end
      StScan: begin
        // abort wins over any bit presented in the same cycle
        if (bus.abort) begin
          aborted_d = 1'b1;
          state_d   = StDone;
        end else if (bus.in_valid) begin
          hist_d = hist_nxt;
          bits_d = bits_q + CNT_W'(1);
          hit    = (fill_nxt == FillFull) && (hist_nxt == pattern_q);
          // non-overlap restarts the fill so the next hit needs PAT_W fresh bits
          fill_d = (hit && !overlap_q) ? '0 : fill_nxt;
          if (hit) begin
            match_d = 1'b1;
            count_d = (count_q == '1) ? count_q : count_q + CNT_W'(1);
          end
          lim_reached = (max_q != '0) && (count_d == max_q);
          if (lim_reached) begin
            limit_d = 1'b1;
          end
          if (lim_reached || (bits_d == window_q)) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      pattern_q <= '0;
      overlap_q <= 1'b0;
      window_q  <= '0;
      max_q     <= '0;
      hist_q    <= '0;
      fill_q    <= '0;
      bits_q    <= '0;
      count_q   <= '0;
      match_q   <= 1'b0;
      limit_q   <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pattern_q <= pattern_d;
      overlap_q <= overlap_d;
      window_q  <= window_d;
      max_q     <= max_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      bits_q    <= bits_d;
      count_q   <= count_d;
      match_q   <= match_d;
      limit_q   <= limit_d;
      aborted_q <= aborted_d;
    end
  end

  assign bus.busy        = (state_q == StScan);
  assign bus.done        = (state_q == StDone);
  assign bus.match       = match_q;
  assign bus.match_count = count_q;
  assign bus.limit_hit   = limit_q;
  assign bus.aborted     = aborted_q;

endmodule

// File: tb/tb_seq_scan_ctrl.sv
module tb_seq_scan_ctrl;
  localparam int unsigned PW = 4;
  localparam int unsigned CW = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seq_scan_if #(.PAT_W(PW), .CNT_W(CW)) bus ();

  seq_scan_ctrl #(.PAT_W(PW), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  int bits_a  [256];
  int gaps_a  [256];
  int exp_hit [256];
  int exp_cnt [256];
  int term_idx;
  int exp_lim;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: string matching over the accepted bit list. A hit is the last PW bits
  // equalling the pattern, counting only bits since the last hit in non-overlap mode.
  task automatic model(input int pat, input int ov, input int win, input int mx);
    int seg, cnt, v;
    seg = 0; cnt = 0; term_idx = -1; exp_lim = 0;
    for (int i = 0; i < win; i++) begin
      exp_hit[i] = 0;
      seg++;
      if (seg >= PW) begin
        v = 0;
        for (int j = 0; j < PW; j++) v = (v << 1) | bits_a[i-PW+1+j];
        if (v == pat) begin
          exp_hit[i] = 1;
          cnt = (cnt < 255) ? cnt + 1 : 255;
          if (ov == 0) seg = 0;
        end
      end
      exp_cnt[i] = cnt;
      if (mx != 0 && cnt == mx) begin
        term_idx = i; exp_lim = 1; break;
      end
      if (i + 1 == win) begin
        term_idx = i; break;
      end
    end
  endtask

  task automatic run_scan(input int pat, input int ov, input int win, input int mx,
                          input int abort_at, input logic junk_start);
    int  cnt;
    logic last;
    model(pat, ov, win, mx);
    bus.cfg_pattern   = PW'(pat);
    bus.cfg_overlap   = ov[0];
    bus.cfg_window    = CW'(win);
    bus.cfg_max_match = CW'(mx);
    bus.start = 1'b1;
    bus.in = $urandom_range(0, 1);
    step();
    bus.start = 1'b0;
    // scramble config; it must be ignored after the start edge
    bus.cfg_pattern   = PW'($urandom);
    bus.cfg_overlap   = 1'($urandom);
    bus.cfg_window    = CW'($urandom_range(1, 3));
    bus.cfg_max_match = CW'($urandom_range(1, 2));
    if (win == 0) begin
      chk("w0_done", bus.done, 1);
      chk("w0_busy", bus.busy, 0);
      chk("w0_count", bus.match_count, 0);
      step();
      chk("w0_done_end", bus.done, 0);
      chk("w0_busy_end", bus.busy, 0);
      return;
    end
    chk("start_busy", bus.busy, 1);
    chk("start_done", bus.done, 0);
    chk("start_count", bus.match_count, 0);
    chk("start_limit", bus.limit_hit, 0);
    chk("start_aborted", bus.aborted, 0);
    cnt = 0;
    for (int i = 0; i < win; i++) begin
      for (int g = 0; g < gaps_a[i]; g++) begin
        bus.in_valid = 1'b0;
        bus.in = $urandom_range(0, 1);
        bus.start = junk_start;
        step();
        bus.start = 1'b0;
        chk("gap_busy", bus.busy, 1);
        chk("gap_match", bus.match, 0);
        chk("gap_count", bus.match_count, cnt);
      end
      if (i == abort_at) begin
        bus.abort = 1'b1;
        bus.in_valid = 1'b1;
        bus.in = $urandom_range(0, 1);
        step();
        bus.abort = 1'b0;
        bus.in_valid = 1'b0;
        chk("abort_done", bus.done, 1);
        chk("abort_flag", bus.aborted, 1);
        chk("abort_busy", bus.busy, 0);
        chk("abort_match", bus.match, 0);
        chk("abort_count", bus.match_count, cnt);
        chk("abort_limit", bus.limit_hit, 0);
        step();
        chk("abort_idle_done", bus.done, 0);
        chk("abort_hold", bus.aborted, 1);
        chk("abort_hold_count", bus.match_count, cnt);
        return;
      end
      bus.in_valid = 1'b1;
      bus.in = bits_a[i][0];
      bus.start = junk_start;
      step();
      bus.start = 1'b0;
      bus.in_valid = 1'b0;
      last = (i == term_idx);
      cnt = exp_cnt[i];
      chk("bit_match", bus.match, exp_hit[i]);
      chk("bit_count", bus.match_count, cnt);
      chk("bit_done", bus.done, last);
      chk("bit_busy", bus.busy, !last);
      chk("bit_limit", bus.limit_hit, last ? exp_lim : 0);
      chk("bit_aborted", bus.aborted, 0);
      if (last) break;
    end
    // bits offered after done must not be consumed
    bus.in_valid = 1'b1;
    bus.in = $urandom_range(0, 1);
    step();
    bus.in_valid = 1'b0;
    chk("end_done", bus.done, 0);
    chk("end_busy", bus.busy, 0);
    chk("end_match", bus.match, 0);
    chk("end_count", bus.match_count, cnt);
    chk("end_limit", bus.limit_hit, exp_lim);
  endtask

  task automatic load_plan_stream();
    int s [12] = '{1, 1, 0, 1, 1, 0, 1, 1, 1, 1, 0, 1};
    for (int i = 0; i < 256; i++) begin
      bits_a[i] = (i < 12) ? s[i] : 0;
      gaps_a[i] = 0;
    end
  endtask

  initial begin
    int win, ab;
    rst = 1'b1;
    bus.start = 1'b0; bus.abort = 1'b0; bus.in_valid = 1'b0; bus.in = 1'b0;
    bus.cfg_pattern = '0; bus.cfg_overlap = 1'b0; bus.cfg_window = '0; bus.cfg_max_match = '0;
    step(); step();
    rst = 1'b0;
    chk("rst_busy", bus.busy, 0);
    chk("rst_match", bus.match, 0);
    chk("rst_count", bus.match_count, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_limit", bus.limit_hit, 0);
    chk("rst_aborted", bus.aborted, 0);

    // Non-overlap
    load_plan_stream();
    run_scan(4'b1101, 0, 12, 0, -1, 1'b0);
    chk("s1_count", bus.match_count, 2);
    chk("s1_limit", bus.limit_hit, 0);

    // Overlap
    run_scan(4'b1101, 1, 12, 0, -1, 1'b0);
    chk("s2_count", bus.match_count, 3);

    // Limit
    run_scan(4'b1101, 0, 12, 1, -1, 1'b0);
    chk("s3_count", bus.match_count, 1);
    chk("s3_limit", bus.limit_hit, 1);

    // Gaps
    gaps_a[2] = 3; gaps_a[9] = 3;
    run_scan(4'b1101, 0, 12, 0, -1, 1'b0);
    chk("s4_count", bus.match_count, 2);

    // Abort after 6 bits, with start pulses during SCAN
    load_plan_stream();
    run_scan(4'b1101, 0, 12, 0, 6, 1'b1);
    chk("s5_count", bus.match_count, 1);
    chk("s5_aborted", bus.aborted, 1);

    // Reset mid-scan after bit 5
    bus.cfg_pattern = 4'b1101; bus.cfg_overlap = 1'b0;
    bus.cfg_window = 8'd12; bus.cfg_max_match = 8'd0;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1; bus.in = bits_a[i][0];
      step();
    end
    chk("pre_rst_count", bus.match_count, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.in_valid = 1'b0;
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_done", bus.done, 0);
    chk("mid_rst_count", bus.match_count, 0);
    chk("mid_rst_match", bus.match, 0);
    step();
    chk("mid_rst_no_done", bus.done, 0);
    run_scan(4'b1101, 0, 12, 0, -1, 1'b0);
    chk("s6_count", bus.match_count, 2);

    // Zero window
    run_scan(4'b1010, 0, 0, 0, -1, 1'b0);

    // Randomized scans against the reference
    for (int t = 0; t < 30; t++) begin
      win = $urandom_range(0, 24);
      for (int i = 0; i < 256; i++) begin
        bits_a[i] = $urandom_range(0, 1);
        gaps_a[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
      end
      ab = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 24) : -1;
      run_scan($urandom_range(0, 15), $urandom_range(0, 1), win, $urandom_range(0, 3),
               ab, 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
